wishbone_master: RTL and testbench
==================================

WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 The block SHALL have parameter ADR_W, default 4, meaning the bus address width.
REQ-002 The block SHALL have parameter DAT_W, default 32, meaning the bus data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the cycles in BUS without ack before abort (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-006 The block SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in ADR_W, cmd_wdata in DAT_W.
REQ-007 The block SHALL have response ports: rsp_valid out 1, rsp_rdata out DAT_W, rsp_err out 1.
REQ-008 The block SHALL have bus ports: adr out ADR_W, dat_mosi out DAT_W, dat_miso in DAT_W, we out 1, cyc out 1, stb out 1, ack in 1.

Function
REQ-009 The block SHALL implement states IDLE, BUS and RESP, with all outputs registered.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge with cmd_valid=1 and cmd_ready=1.
REQ-011 On accept, the block SHALL latch cmd_we/cmd_adr/cmd_wdata into we/adr/dat_mosi, set cyc=stb=1 and enter BUS; cyc/stb are high from the next cycle.
REQ-012 In BUS, adr, we, dat_mosi, cyc and stb SHALL remain stable until the transfer ends.
REQ-013 On an edge in BUS with ack=1, the block SHALL clear cyc/stb, enter RESP and latch rsp_rdata=dat_miso for reads or 0 for writes, with rsp_err=0.
REQ-014 In RESP, rsp_valid SHALL be 1 for exactly one cycle, after which the block returns to IDLE; there is no response backpressure.
REQ-015 Latency SHALL be: accept at edge N gives cyc high in cycle N+1; ack sampled at edge M gives rsp_valid high in cycle M+1 and cmd_ready high in cycle M+2.
REQ-016 With ack held high from cycle N+1, the block SHALL complete one transfer in 3 cycles (accept to next cmd_ready).
REQ-017 ack sampled outside BUS SHALL be ignored, with no state change.
REQ-018 cmd_valid while cmd_ready=0 SHALL be ignored; the requester holds the command until accepted.
REQ-019 rsp_rdata and rsp_err SHALL hold their values until the next response.

Reset
REQ-020 On rst=1 at an edge, the block SHALL enter IDLE and set cyc=stb=we=0, adr=0, dat_mosi=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0, and clear the timeout counter.
REQ-021 cmd_ready SHALL go high in the first cycle after rst deasserts.
REQ-022 Reset during BUS SHALL drop cyc/stb at that edge with no response generated for the aborted transfer.

Configuration
REQ-023 With macro WB_MASTER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on accept and increment each cycle in BUS.
REQ-024 With WB_MASTER_TIMEOUT_EN defined, if ack=0 on the edge where the count equals TIMEOUT_CYC-1, the block SHALL clear cyc/stb and enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 With WB_MASTER_TIMEOUT_EN defined, ack=1 on that same edge SHALL win: the transfer completes normally with rsp_err=0.
REQ-026 Without WB_MASTER_TIMEOUT_EN, the block SHALL wait in BUS indefinitely, rsp_err SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-027 Shared package wb_pkg SHALL hold the default ADR_W/DAT_W constants, the state enum type wb_mst_state_t and the TIMEOUT_CYC default.
REQ-028 The block SHALL be a single module with no sub-modules; the timeout counter stays inline under the macro.

Verification
REQ-029 Write to adr=1, data 0xDEADBEEF, with ack one cycle after cyc -> bus shows adr=1, we=1, dat_mosi=0xDEADBEEF stable until ack, then one rsp_valid pulse with rsp_err=0.
REQ-030 Read from adr=2 with the responder returning 0xCAFEBABE on ack -> rsp_rdata=0xCAFEBABE, rsp_err=0, and cyc low the cycle after ack.
REQ-031 cmd_valid held for two commands with ack tied high -> two transfers, each 3 cycles accept-to-ready, with no overlap of cyc.
REQ-032 Timeout with the macro defined, TIMEOUT_CYC=16 and no ack -> cyc high for exactly 16 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-033 Timeout race with the macro defined -> ack on the 16th BUS cycle gives rsp_err=0; without the macro, ack after 100 cycles gives a normal completion.
REQ-034 rst pulsed mid-BUS -> cyc/stb low after that edge, no rsp_valid, and cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and state type for the Wishbone master.
package wb_pkg;

  localparam int unsigned WB_ADR_W       = 4;
  localparam int unsigned WB_DAT_W       = 32;
  localparam int unsigned WB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_mst_state_t;

endpackage

// File: rtl/wishbone_master.sv
// Single-transfer Wishbone classic master: command in, one bus cycle, one response pulse.
// Optional bus timeout is enabled with macro WB_MASTER_TIMEOUT_EN.
import wb_pkg::*;

module wishbone_master #(
  parameter int unsigned ADR_W       = WB_ADR_W,
  parameter int unsigned DAT_W       = WB_DAT_W,
  parameter int unsigned TIMEOUT_CYC = WB_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [DAT_W-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] dat_mosi,
  input  logic [DAT_W-1:0] dat_miso,
  output logic             we,
  output logic             cyc,
  output logic             stb,
  input  logic             ack
);

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("wishbone_master: TIMEOUT_CYC must be in 1..255");
  end

  wb_mst_state_t    state, state_n;
  logic             cmd_ready_n;
  logic             cyc_n, stb_n, we_n;
  logic [ADR_W-1:0] adr_n;
  logic [DAT_W-1:0] dat_mosi_n;
  logic             rsp_valid_n;
  logic [DAT_W-1:0] rsp_rdata_n;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt, cnt_n;
  logic       rsp_err_q, rsp_err_n;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready;
    cyc_n       = cyc;
    stb_n       = stb;
    we_n        = we;
    adr_n       = adr;
    dat_mosi_n  = dat_mosi;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_n       = cnt;
    rsp_err_n   = rsp_err_q;
`endif
    case (state)
      ST_IDLE: begin
        // cmd_ready is its own flop so it stays low for one cycle after reset
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          we_n        = cmd_we;
          adr_n       = cmd_adr;
          dat_mosi_n  = cmd_wdata;
          cyc_n       = 1'b1;
          stb_n       = 1'b1;
          state_n     = ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_n       = '0;
`endif
        end
      end
      ST_BUS: begin
        if (ack) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = we ? '0 : dat_miso;
          state_n     = ST_RESP;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_n   = 1'b0;
        end else if (cnt == TO_LAST) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b1;
          state_n     = ST_RESP;
        end else begin
          cnt_n       = cnt + 8'd1;
`endif
        end
      end
      ST_RESP: begin
        cmd_ready_n = 1'b1;
        state_n     = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      dat_mosi  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt       <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      cyc       <= cyc_n;
      stb       <= stb_n;
      we        <= we_n;
      adr       <= adr_n;
      dat_mosi  <= dat_mosi_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt       <= cnt_n;
      rsp_err_q <= rsp_err_n;
`endif
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: directed scenarios plus randomized transfers vs. a cycle-count model.
module tb_wishbone_master;

  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned TO    = 16;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_wdata;
  logic             rsp_valid, rsp_err;
  logic [DAT_W-1:0] rsp_rdata;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_mosi, dat_miso;
  logic             we, cyc, stb, ack;

  int total = 0;
  int bad   = 0;

  wishbone_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr(adr), .dat_mosi(dat_mosi), .dat_miso(dat_miso),
    .we(we), .cyc(cyc), .stb(stb), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer: 'delay' idle-ack BUS cycles before ack; the model derives
  // the number of cyc-high cycles and the response from the timeout rule.
  task automatic txn(input logic w, input logic [ADR_W-1:0] a, input logic [DAT_W-1:0] d,
                     input int delay, input logic [DAT_W-1:0] miso);
    int n = 0;
    bit timed_out;
    int exp_cycles;
    logic [DAT_W-1:0] exp_rdata;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", 64'(cmd_ready), 64'd1);
    timed_out  = TO_EN && (delay >= int'(TO));
    exp_cycles = timed_out ? int'(TO) : delay + 1;
    exp_rdata  = (timed_out || w) ? '0 : miso;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_wdata = d;
    step();
    for (int c = 1; c <= exp_cycles; c++) begin
      check("bus_hold", 64'({cyc, stb, we, adr, dat_mosi, cmd_ready, rsp_valid}),
            64'({1'b1, 1'b1, w, a, d, 1'b0, 1'b0}));
      // garbage command while busy must be ignored
      cmd_valid = 1'($urandom); cmd_we = 1'($urandom);
      cmd_adr = ADR_W'($urandom); cmd_wdata = $urandom;
      dat_miso = $urandom;
      ack = 1'b0;
      if (c == delay + 1) begin
        ack = 1'b1;
        dat_miso = miso;
      end
      step();
    end
    check("rsp_flags", 64'({cyc, stb, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("rsp_err", 64'(rsp_err), 64'(timed_out));
    cmd_valid = 1'b0;
    ack = 1'($urandom);
    dat_miso = $urandom;
    step();
    check("after_rsp", 64'({cyc, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
    check("rsp_hold", 64'({rsp_rdata, rsp_err}), 64'({exp_rdata, timed_out}));
    ack = 1'b0;
  endtask

  initial begin
    logic [2:0] b2b_exp [1:6];
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdata = '0;
    dat_miso = '0; ack = 1'b0;
    @(negedge clk);
    step();
    check("reset_state", 64'({cyc, stb, we, adr, dat_mosi, rsp_valid, rsp_rdata, rsp_err, cmd_ready}), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // ack while idle is ignored
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ack", 64'({cyc, stb, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
    end
    ack = 1'b0;

    txn(1'b1, 4'd1, 32'hDEADBEEF, 1, 32'h1234_5678);
    txn(1'b0, 4'd2, 32'h0000_0000, 2, 32'hCAFEBABE);

    // back-to-back commands with ack tied high: one transfer every 3 cycles
    b2b_exp[1] = 3'b100; b2b_exp[2] = 3'b001; b2b_exp[3] = 3'b010;
    b2b_exp[4] = 3'b100; b2b_exp[5] = 3'b001; b2b_exp[6] = 3'b010;
    cmd_valid = 1'b1; cmd_we = 1'b0; ack = 1'b1;
    cmd_adr = 4'd8; dat_miso = 32'h1111_1111;
    step();
    for (int k = 1; k <= 6; k++) begin
      check("b2b_flags", 64'({cyc, cmd_ready, rsp_valid}), 64'(b2b_exp[k]));
      if (k == 1) check("b2b_adr0", 64'(adr), 64'd8);
      if (k == 2) check("b2b_rd0", 64'(rsp_rdata), 64'h2222_2222);
      if (k == 4) check("b2b_adr1", 64'(adr), 64'd11);
      if (k == 5) check("b2b_rd1", 64'(rsp_rdata), 64'h5555_5555);
      cmd_adr = ADR_W'(8 + k);
      dat_miso = 32'h1111_1111 * (k + 1);
      if (k == 6) cmd_valid = 1'b0;
      step();
    end
    ack = 1'b0;

    // timeout boundary, race, and a long wait
    txn(1'b0, 4'd3, 32'h0, 16, 32'hA5A5_A5A5);
    txn(1'b0, 4'd4, 32'h0, 15, 32'h5A5A_5A5A);
    txn(1'b1, 4'd5, 32'h0BAD_F00D, 100, 32'h7777_7777);

    for (int i = 0; i < 20; i++) begin
      txn(1'($urandom), ADR_W'($urandom), $urandom, int'($urandom_range(0, 20)), $urandom);
    end

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'd7; cmd_wdata = 32'h0123_4567;
    step();
    cmd_valid = 1'b0;
    check("mid_bus", 64'({cyc, stb}), 64'({1'b1, 1'b1}));
    step();
    rst = 1'b1;
    step();
    check("rst_abort", 64'({cyc, stb, rsp_valid, cmd_ready, adr}), 64'd0);
    rst = 1'b0;
    step();
    check("rst_release", 64'({cyc, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
    step();
    check("rst_no_rsp", 64'({cyc, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));

    txn(1'b0, 4'd9, 32'h0, 0, 32'hFEED_FACE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
